// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper pulse generator.
package stepper_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  // Magnitude of a two's-complement value; the most negative input maps to 2^(W-1) unsigned.
  function automatic logic [DEF_WIDTH-1:0] abs_u32(input logic [DEF_WIDTH-1:0] v);
    return v[DEF_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/stepper_pulse_gen.sv
// Step-pulse sequencer: LOW/HIGH phase FSM, phase counter and remaining-step counter.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int WIDTH       = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  output logic             step,
  output logic             step_rise
);
  localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] remaining, remaining_nxt;
  logic             setup, setup_nxt;
  logic             step_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      setup     <= 1'b0;
      step      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      remaining <= remaining_nxt;
      setup     <= setup_nxt;
      step      <= step_nxt;
    end
  end

  // The first LOW after a start is one cycle longer (setup), so DIR leads STEP by a full half period.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    remaining_nxt = remaining;
    setup_nxt     = setup;
    step_nxt      = step;
    step_rise     = 1'b0;
    if (start) begin
      state_nxt     = (count != '0) ? LOW : IDLE;
      cnt_nxt       = '0;
      remaining_nxt = count;
      setup_nxt     = (count != '0);
      step_nxt      = 1'b0;
    end else begin
      case (state)
        LOW: begin
          if (setup) begin
            setup_nxt = 1'b0;
          end else if (cnt == LAST) begin
            state_nxt     = HIGH;
            cnt_nxt       = '0;
            step_nxt      = 1'b1;
            step_rise     = 1'b1;
            remaining_nxt = remaining - 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            step_nxt  = 1'b0;
            state_nxt = (remaining != '0) ? LOW : IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/stepper.sv
// Memory-mapped stepper-motor controller: bus register, direction, absolute position.
module stepper
  import stepper_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int WIDTH       = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] writedata,
  input  logic             read,
  output logic [WIDTH-1:0] readdata,
  output logic             step,
  output logic             dir
);
  logic [WIDTH-1:0] position;
  logic [WIDTH-1:0] move_abs;
  logic             step_rise;

  assign move_abs = abs_u32(writedata);

  stepper_pulse_gen #(
    .HALF_PERIOD(HALF_PERIOD),
    .WIDTH      (WIDTH)
  ) u_pulse_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (write),
    .count    (move_abs),
    .step     (step),
    .step_rise(step_rise)
  );

  // readdata samples position before any same-edge update, so reads see the pre-step value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir      <= 1'b1;
      position <= '0;
      readdata <= '0;
    end else begin
      if (write)     dir      <= ~writedata[WIDTH-1];
      if (step_rise) position <= dir ? position + 1'b1 : position - 1'b1;
      if (read)      readdata <= position;
    end
  end
endmodule

// File: tb/tb_stepper.sv
// Self-checking bench for stepper: vector table, corner sequences, randomized moves vs timing model.
module tb_stepper;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        step, dir;

  always #5 clk = ~clk;

  stepper #(.HALF_PERIOD(H), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .step(step), .dir(dir)
  );

  int tests = 0, fails = 0;

  // Model: the last move started at edge m_k with m_n steps from position m_base.
  longint      cyc = 0, m_k = 0, m_n = 0;
  logic [31:0] m_base = '0, m_rd = '0;
  logic        m_dir = 1'b1;
  int          pulses = 0, hi_len = 0;
  logic        prev_step = 1'b0;
  bit          chk_width = 1'b0;

  function automatic longint rises_at(longint t);
    longint d;
    if (m_n == 0 || t < m_k + 1 + H) return 0;
    d = (t - m_k - 1 - H) / (2 * H) + 1;
    return (d < m_n) ? d : m_n;
  endfunction

  function automatic logic [31:0] pos_at(longint t);
    longint r;
    r = rises_at(t);
    return m_dir ? m_base + 32'(r) : m_base - 32'(r);
  endfunction

  function automatic logic step_at(longint t);
    longint d;
    if (m_n == 0 || t < m_k + 1 + H) return 1'b0;
    d = t - m_k - 1 - H;
    return ((d / (2 * H)) < m_n) && ((d % (2 * H)) < H);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock edge: update the model with the inputs about to be sampled, then check outputs.
  task automatic tick();
    logic [31:0] cur;
    cur = pos_at(cyc);
    if (read) m_rd = cur;
    if (write) begin
      m_base = cur;
      m_k    = cyc + 1;
      m_n    = writedata[31] ? (64'sh1_0000_0000 - longint'(writedata)) : longint'(writedata);
      m_dir  = ~writedata[31];
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("step", step, step_at(cyc));
    chk("dir", dir, m_dir);
    chk("readdata", readdata, m_rd);
    if (step && !prev_step) pulses++;
    if (step) hi_len++;
    else begin
      if (prev_step && chk_width) chk("high_width", hi_len, H);
      hi_len = 0;
    end
    prev_step = step;
  endtask

  task automatic wr(input logic [31:0] d);
    write = 1'b1; writedata = d;
    tick();
    write = 1'b0;
  endtask

  task automatic rd();
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_base = '0; m_n = 0; m_dir = 1'b1; m_rd = '0; m_k = cyc;
    chk("reset_step", step, 1'b0);
    chk("reset_dir", dir, 1'b1);
    chk("reset_readdata", readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hi_len = 0; prev_step = 1'b0; pulses = 0;
  endtask

  typedef struct {
    logic [31:0] wd;
    int          npulse;
    logic        edir;
    logic [31:0] epos;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{32'd10,         10, 1'b1, 32'd10};
    vt[1] = '{32'hFFFF_FFF6,  10, 1'b0, 32'd0};
    vt[2] = '{32'd1,           1, 1'b1, 32'd1};
    vt[3] = '{32'hFFFF_FFFF,   1, 1'b0, 32'd0};
    vt[4] = '{32'hFFFF_FFFD,   3, 1'b0, 32'hFFFF_FFFD};
    vt[5] = '{32'd5,           5, 1'b1, 32'd2};

    // Reset and quiet period
    do_reset();
    idle(50);
    chk("quiet_pulses", pulses, 0);

    // Complete moves from the table; positions accumulate
    chk_width = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulses = 0;
      wr(vt[i].wd);
      idle(2 * H * vt[i].npulse + 4);
      chk("move_pulses", pulses, vt[i].npulse);
      chk("move_dir", dir, vt[i].edir);
      rd();
      chk("move_pos", readdata, vt[i].epos);
    end
    chk_width = 1'b0;

    // Retarget after 5 pulses of a 100-step move
    do_reset();
    wr(32'd100);
    for (int i = 0; i < 300 && pulses < 5; i++) tick();
    chk("retarget_wait", pulses, 5);
    wr(32'd3);
    chk("retarget_trunc", step, 1'b0);
    idle(2 * H * 3 + 4);
    chk("retarget_pulses", pulses, 8);
    rd();
    chk("retarget_pos", readdata, 32'd8);

    // Stop with a zero write mid-pulse
    do_reset();
    wr(32'd20);
    for (int i = 0; i < 300 && pulses < 3; i++) tick();
    chk("stop_wait", pulses, 3);
    tick();
    wr(32'd0);
    chk("stop_step", step, 1'b0);
    idle(40);
    chk("stop_pulses", pulses, 3);
    rd();
    chk("stop_pos", readdata, 32'd3);

    // Read coinciding with a step rise
    do_reset();
    wr(32'd2);
    idle(H);
    rd();
    chk("rise_read_old", readdata, 32'd0);
    chk("rise_read_step", step, 1'b1);
    rd();
    chk("rise_read_new", readdata, 32'd1);
    idle(2 * H * 2);

    // Simultaneous read and write returns the position before the new move
    read = 1'b1;
    wr(32'd4);
    read = 1'b0;
    chk("rw_same_edge", readdata, 32'd2);
    idle(2 * H * 4 + 4);

    // Most negative move, then reset mid-move
    wr(32'h8000_0000);
    idle(H + 1 + 4 * H);
    chk("minint_dir", dir, 1'b0);
    do_reset();
    idle(5);
    chk("reset_midmove_pulses", pulses, 0);
    rd();
    chk("reset_midmove_pos", readdata, 32'd0);

    // Randomized moves, interruptions and reads checked against the model
    for (int it = 0; it < 40; it++) begin
      int          n;
      int          w;
      logic [31:0] d;
      n = $urandom_range(0, 12);
      d = ($urandom_range(0, 1) == 1) ? (32'd0 - 32'(n)) : 32'(n);
      read = ($urandom_range(0, 3) == 0);
      wr(d);
      read = 1'b0;
      w = $urandom_range(0, 2 * H * n + 6);
      for (int c = 0; c < w; c++) begin
        read = ($urandom_range(0, 3) == 0);
        tick();
        read = 1'b0;
      end
    end
    idle(2 * H * 12 + 4);
    rd();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
